// File: rtl/nand_target_io.sv
// Device-side ONFI NAND pin responder.
// Samples the controller's pins, turns WE# rising edges into command/address/data
// strobes, answers RE# falling edges from a read FIFO or the status register, and
// drives R/B# from a busy timer.
module nand_target_io #(
  parameter int FIFO_DEPTH = 16,
  parameter int T_BUSY     = 64,
  parameter int T_RST      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nand_ce_n,
  input  logic        nand_cle,
  input  logic        nand_ale,
  input  logic        nand_we_n,
  input  logic        nand_re_n,
  input  logic        nand_wp_n,
  input  logic [15:0] nand_dq_in,
  output logic [15:0] nand_dq_out,
  output logic        nand_dq_oe,
  output logic        nand_rb_n,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        addr_valid,
  output logic [7:0]  addr_byte,
  output logic [2:0]  addr_index,
  output logic        data_valid,
  output logic [15:0] data_word,
  input  logic        fill_valid,
  input  logic [15:0] fill_data,
  output logic        fill_ready,
  output logic        underrun
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int TMAX = (T_BUSY > T_RST) ? T_BUSY : T_RST;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [TW-1:0] BUSY_LOAD = TW'(T_BUSY - 1);
  localparam logic [TW-1:0] RST_LOAD  = TW'(T_RST - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] TMR_ZERO  = TW'(0);

  typedef enum logic {BSY_READY = 1'b0, BSY_BUSY = 1'b1} busy_state_e;
  typedef enum logic {MODE_ARRAY = 1'b0, MODE_STATUS = 1'b1} read_mode_e;

  // Pin sampling: first stage for every pin, second stage only for the strobes.
  logic        r_ce_n_q, r_cle_q, r_ale_q, r_we_n_q, r_re_n_q, r_wp_n_q;
  logic [15:0] r_dq_q;
  logic        d_we_n_q, d_re_n_q;

  busy_state_e busy_q, busy_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        rb_n_q;
  read_mode_e  mode_q, mode_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        addr_valid_q, addr_valid_d;
  logic [7:0]  addr_byte_q, addr_byte_d;
  logic [2:0]  addr_index_q, addr_index_d;
  logic [2:0]  idx_q, idx_d;
  logic        data_valid_q, data_valid_d;
  logic [15:0] data_word_q, data_word_d;

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        fill_ready_q, fill_ready_d;
  logic        underrun_q, underrun_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;

  logic        we_rise_s, re_fall_s, re_rise_s;
  logic        cmd_det_s, addr_det_s, data_det_s;
  logic [7:0]  cmd_code_s;
  logic        cmd_acc_s, cmd_rst_s, cmd_conf_s;
  logic        fifo_empty_s, push_s, pop_s;

  assign we_rise_s  = ~r_ce_n_q & r_we_n_q & ~d_we_n_q;
  assign re_fall_s  = ~r_ce_n_q & ~r_re_n_q & d_re_n_q;
  assign re_rise_s  = r_re_n_q & ~d_re_n_q;
  assign cmd_det_s  = we_rise_s & r_cle_q & ~r_ale_q;
  assign addr_det_s = we_rise_s & r_ale_q & ~r_cle_q;
  assign data_det_s = we_rise_s & ~r_cle_q & ~r_ale_q;
  assign cmd_code_s = r_dq_q[7:0];
  // While busy only read-status and reset get through.
  assign cmd_acc_s  = cmd_det_s & (rb_n_q | (cmd_code_s == 8'h70) | (cmd_code_s == 8'hFF));
  assign cmd_rst_s  = cmd_acc_s & (cmd_code_s == 8'hFF);
  assign cmd_conf_s = cmd_acc_s & ((cmd_code_s == 8'h10) | (cmd_code_s == 8'h30) |
                                   (cmd_code_s == 8'hD0));

  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign push_s       = fill_valid & fill_ready_q & ~cmd_rst_s;
  assign pop_s        = re_fall_s & (mode_q == MODE_ARRAY) & ~fifo_empty_s & ~cmd_rst_s;

  // Busy timer: confirm/reset commands load the timer, then count down to ready.
  always_comb begin
    busy_d  = busy_q;
    timer_d = timer_q;
    if (cmd_rst_s) begin
      busy_d  = BSY_BUSY;
      timer_d = RST_LOAD;
    end else if (cmd_conf_s) begin
      busy_d  = BSY_BUSY;
      timer_d = BUSY_LOAD;
    end else begin
      case (busy_q)
        BSY_READY: begin
          busy_d  = BSY_READY;
          timer_d = timer_q;
        end
        BSY_BUSY: begin
          if (timer_q == TMR_ZERO) begin
            busy_d  = BSY_READY;
            timer_d = TMR_ZERO;
          end else begin
            busy_d  = BSY_BUSY;
            timer_d = timer_q - TMR_ONE;
          end
        end
        default: begin
          busy_d  = BSY_READY;
          timer_d = TMR_ZERO;
        end
      endcase
    end
  end

  // Read mode: status after 0x70, array after any other accepted command.
  always_comb begin
    mode_d = mode_q;
    if (cmd_acc_s) begin
      if (cmd_code_s == 8'h70) begin
        mode_d = MODE_STATUS;
      end else begin
        mode_d = MODE_ARRAY;
      end
    end else begin
      mode_d = mode_q;
    end
  end

  // Turn detected WE# rises into command/address/data strobes.
  always_comb begin
    cmd_valid_d  = cmd_acc_s;
    cmd_byte_d   = cmd_byte_q;
    addr_valid_d = addr_det_s;
    addr_byte_d  = addr_byte_q;
    addr_index_d = addr_index_q;
    idx_d        = idx_q;
    data_valid_d = data_det_s & r_wp_n_q & rb_n_q;
    data_word_d  = data_word_q;
    if (cmd_acc_s) begin
      cmd_byte_d   = cmd_code_s;
      addr_index_d = 3'd0;
      idx_d        = 3'd0;
    end else if (addr_det_s) begin
      addr_byte_d  = cmd_code_s;
      addr_index_d = idx_q;
      idx_d        = (idx_q == 3'd7) ? 3'd7 : (idx_q + 3'd1);
    end else begin
      idx_d = idx_q;
    end
    if (data_valid_d) begin
      data_word_d = r_dq_q;
    end else begin
      data_word_d = data_word_q;
    end
  end

  // Read path: FIFO pointers, DQ drive, output enable and the underrun flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    underrun_d = underrun_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;

    if (re_fall_s) begin
      if (mode_q == MODE_STATUS) begin
        dq_out_d = {8'h00, r_wp_n_q, rb_n_q, rb_n_q, 5'b00000};
      end else if (!fifo_empty_s) begin
        dq_out_d = mem_q[rd_ptr_q];
      end else begin
        dq_out_d   = 16'hFFFF;
        underrun_d = 1'b1;
      end
    end else begin
      dq_out_d = dq_out_q;
    end

    if (r_ce_n_q) begin
      dq_oe_d = 1'b0;
    end else if (re_fall_s) begin
      dq_oe_d = 1'b1;
    end else if (re_rise_s) begin
      dq_oe_d = 1'b0;
    end else begin
      dq_oe_d = dq_oe_q;
    end

    if (cmd_rst_s) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      underrun_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    fill_ready_d = (count_d != FULL_CNT);
  end

  // FIFO storage; contents are don't-care once the count says empty.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= fill_data;
    end
  end

  // Pin sampling stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_n_q <= 1'b1;
      r_cle_q  <= 1'b0;
      r_ale_q  <= 1'b0;
      r_we_n_q <= 1'b1;
      r_re_n_q <= 1'b1;
      r_wp_n_q <= 1'b1;
      r_dq_q   <= 16'h0000;
      d_we_n_q <= 1'b1;
      d_re_n_q <= 1'b1;
    end else begin
      r_ce_n_q <= nand_ce_n;
      r_cle_q  <= nand_cle;
      r_ale_q  <= nand_ale;
      r_we_n_q <= nand_we_n;
      r_re_n_q <= nand_re_n;
      r_wp_n_q <= nand_wp_n;
      r_dq_q   <= nand_dq_in;
      d_we_n_q <= r_we_n_q;
      d_re_n_q <= r_re_n_q;
    end
  end

  // State registers for the FSMs, strobes and read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= BSY_READY;
      timer_q      <= TMR_ZERO;
      rb_n_q       <= 1'b1;
      mode_q       <= MODE_ARRAY;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= 8'h00;
      addr_valid_q <= 1'b0;
      addr_byte_q  <= 8'h00;
      addr_index_q <= 3'd0;
      idx_q        <= 3'd0;
      data_valid_q <= 1'b0;
      data_word_q  <= 16'h0000;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      fill_ready_q <= 1'b1;
      underrun_q   <= 1'b0;
      dq_out_q     <= 16'hFFFF;
      dq_oe_q      <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      rb_n_q       <= (busy_d == BSY_READY);
      mode_q       <= mode_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      addr_valid_q <= addr_valid_d;
      addr_byte_q  <= addr_byte_d;
      addr_index_q <= addr_index_d;
      idx_q        <= idx_d;
      data_valid_q <= data_valid_d;
      data_word_q  <= data_word_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fill_ready_q <= fill_ready_d;
      underrun_q   <= underrun_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  assign nand_dq_out = dq_out_q;
  assign nand_dq_oe  = dq_oe_q;
  assign nand_rb_n   = rb_n_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign addr_valid  = addr_valid_q;
  assign addr_byte   = addr_byte_q;
  assign addr_index  = addr_index_q;
  assign data_valid  = data_valid_q;
  assign data_word   = data_word_q;
  assign fill_ready  = fill_ready_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_nand_target_io.sv
// Self-checking bench for nand_target_io: directed pin sequences, a cycle-indexed
// expectation model for strobes and R/B#, and a queue model for the read FIFO.
module tb_nand_target_io;
  localparam int DEPTH  = 16;
  localparam int TBUSY  = 64;
  localparam int TRST   = 16;
  localparam int NCYC   = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n, nand_wp_n;
  logic [15:0] nand_dq_in, nand_dq_out;
  logic        nand_dq_oe, nand_rb_n;
  logic        cmd_valid, addr_valid, data_valid;
  logic [7:0]  cmd_byte, addr_byte;
  logic [2:0]  addr_index;
  logic [15:0] data_word;
  logic        fill_valid, fill_ready, underrun;
  logic [15:0] fill_data;

  nand_target_io #(.FIFO_DEPTH(DEPTH), .T_BUSY(TBUSY), .T_RST(TRST)) dut (
    .clk(clk), .rst(rst), .nand_ce_n(nand_ce_n), .nand_cle(nand_cle), .nand_ale(nand_ale),
    .nand_we_n(nand_we_n), .nand_re_n(nand_re_n), .nand_wp_n(nand_wp_n),
    .nand_dq_in(nand_dq_in), .nand_dq_out(nand_dq_out), .nand_dq_oe(nand_dq_oe),
    .nand_rb_n(nand_rb_n), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .addr_valid(addr_valid), .addr_byte(addr_byte), .addr_index(addr_index),
    .data_valid(data_valid), .data_word(data_word), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_ready(fill_ready), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle strobe and R/B# values, indexed by posedge count.
  bit          exp_cmd_v  [NCYC];
  logic [7:0]  exp_cmd_b  [NCYC];
  bit          exp_addr_v [NCYC];
  logic [7:0]  exp_addr_b [NCYC];
  logic [2:0]  exp_addr_i [NCYC];
  bit          exp_data_v [NCYC];
  logic [15:0] exp_data_w [NCYC];
  bit          exp_rb     [NCYC];

  logic [15:0] fifo_m[$];
  bit          under_m = 1'b0;
  bit          status_m = 1'b0;
  int          aidx_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_busy(input int s, input int t);
    for (int c = s; c < s + 300 && c < NCYC; c++) exp_rb[c] = (c < s + t) ? 1'b0 : 1'b1;
  endtask

  // Register what a WE# rise driven at cycle k must produce two cycles later.
  task automatic model_we(input logic cle, input logic ale, input logic [15:0] dq, input int k);
    int  s;
    bit  acc;
    s = k + 2;
    if (cle && !ale) begin
      acc = exp_rb[s-1] || (dq[7:0] == 8'h70) || (dq[7:0] == 8'hFF);
      if (acc) begin
        exp_cmd_v[s] = 1'b1;
        exp_cmd_b[s] = dq[7:0];
        aidx_m = 0;
        status_m = (dq[7:0] == 8'h70);
        if (dq[7:0] == 8'hFF) begin
          set_busy(s, TRST);
          fifo_m.delete();
          under_m = 1'b0;
        end else if (dq[7:0] == 8'h10 || dq[7:0] == 8'h30 || dq[7:0] == 8'hD0) begin
          set_busy(s, TBUSY);
        end
      end
    end else if (ale && !cle) begin
      exp_addr_v[s] = 1'b1;
      exp_addr_b[s] = dq[7:0];
      exp_addr_i[s] = 3'(aidx_m);
      aidx_m = (aidx_m < 7) ? aidx_m + 1 : 7;
    end else if (!cle && !ale) begin
      if (nand_wp_n && exp_rb[s-1]) begin
        exp_data_v[s] = 1'b1;
        exp_data_w[s] = dq;
      end
    end
  endtask

  task automatic we_pulse(input logic cle, input logic ale, input logic [15:0] dq);
    int k;
    @(negedge clk);
    nand_cle = cle; nand_ale = ale; nand_dq_in = dq; nand_we_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nand_we_n = 1'b1;
    k = cyc;
    model_we(cle, ale, dq, k);
    @(negedge clk);
    @(negedge clk);
    nand_cle = 1'b0; nand_ale = 1'b0;
  endtask

  task automatic re_pulse(output logic [15:0] got);
    int k;
    logic [15:0] e;
    @(negedge clk);
    nand_re_n = 1'b0;
    k = cyc;
    if (status_m) e = {8'h00, nand_wp_n, exp_rb[k+1], exp_rb[k+1], 5'b00000};
    else if (fifo_m.size() > 0) e = fifo_m.pop_front();
    else begin
      e = 16'hFFFF;
      under_m = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    chk("re_oe_on", 32'(nand_dq_oe), 32'd1);
    chk("re_dq", 32'(nand_dq_out), 32'(e));
    chk("re_underrun", 32'(underrun), 32'(under_m));
    got = nand_dq_out;
    nand_re_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("re_oe_off", 32'(nand_dq_oe), 32'd0);
    chk("re_dq_hold", 32'(nand_dq_out), 32'(e));
  endtask

  task automatic push(input logic [15:0] w);
    bit r;
    @(negedge clk);
    r = (fifo_m.size() < DEPTH);
    chk("fill_ready", 32'(fill_ready), 32'(r));
    fill_valid = 1'b1;
    fill_data = w;
    if (r) fifo_m.push_back(w);
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic rb_low_len(output int n);
    n = 0;
    while (nand_rb_n == 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Compare strobes and R/B# against the cycle-indexed expectations.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      chk("cmd_valid", 32'(cmd_valid), 32'(exp_cmd_v[cyc]));
      if (exp_cmd_v[cyc]) chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_b[cyc]));
      chk("addr_valid", 32'(addr_valid), 32'(exp_addr_v[cyc]));
      if (exp_addr_v[cyc]) begin
        chk("addr_byte", 32'(addr_byte), 32'(exp_addr_b[cyc]));
        chk("addr_index", 32'(addr_index), 32'(exp_addr_i[cyc]));
      end
      chk("data_valid", 32'(data_valid), 32'(exp_data_v[cyc]));
      if (exp_data_v[cyc]) chk("data_word", 32'(data_word), 32'(exp_data_w[cyc]));
      chk("rb_n", 32'(nand_rb_n), 32'(exp_rb[cyc]));
    end
  end

  logic [15:0] got;
  int          n;
  logic [7:0]  addrs [5];

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      exp_cmd_v[i] = 1'b0; exp_addr_v[i] = 1'b0; exp_data_v[i] = 1'b0; exp_rb[i] = 1'b1;
      exp_cmd_b[i] = 8'h00; exp_addr_b[i] = 8'h00; exp_addr_i[i] = 3'd0; exp_data_w[i] = 16'h0;
    end
    rst = 1'b1; nand_ce_n = 1'b0; nand_cle = 1'b0; nand_ale = 1'b0; nand_we_n = 1'b1;
    nand_re_n = 1'b1; nand_wp_n = 1'b1; nand_dq_in = 16'h0000;
    fill_valid = 1'b0; fill_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_dq_out", 32'(nand_dq_out), 32'hFFFF);
    chk("rst_dq_oe", 32'(nand_dq_oe), 32'd0);
    chk("rst_rb_n", 32'(nand_rb_n), 32'd1);
    chk("rst_valids", 32'({cmd_valid, addr_valid, data_valid}), 32'd0);
    chk("rst_bytes", 32'({cmd_byte, addr_byte, addr_index}), 32'd0);
    chk("rst_data_word", 32'(data_word), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_fill_ready", 32'(fill_ready), 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    // Page read setup: command, five address cycles, confirm.
    addrs[0] = 8'h12; addrs[1] = 8'h34; addrs[2] = 8'h56; addrs[3] = 8'h78; addrs[4] = 8'h9A;
    we_pulse(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) we_pulse(1'b0, 1'b1, {8'h00, addrs[i]});
    we_pulse(1'b1, 1'b0, 16'h0030);
    rb_low_len(n);
    chk("busy_len_64", 32'(n), 32'd64);

    // Address index saturation, then data-in with and without write protect.
    we_pulse(1'b1, 1'b0, 16'h0080);
    for (int i = 0; i < 10; i++) we_pulse(1'b0, 1'b1, 16'(8'hA0 + i));
    chk("addr_idx_sat", 32'(addr_index), 32'd7);
    we_pulse(1'b0, 1'b0, 16'hBEEF);
    nand_wp_n = 1'b0;
    we_pulse(1'b0, 1'b0, 16'hCAFE);
    nand_wp_n = 1'b1;

    // Array reads from the FIFO, then underrun.
    we_pulse(1'b1, 1'b0, 16'h0000);
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    re_pulse(got); chk("rd_1111", 32'(got), 32'h1111);
    re_pulse(got);
    re_pulse(got);
    re_pulse(got); chk("rd_4444", 32'(got), 32'h4444);
    re_pulse(got); chk("rd_empty", 32'(got), 32'hFFFF);
    chk("underrun_set", 32'(underrun), 32'd1);

    // Fill to full, drop the extra push, drain everything.
    for (int i = 0; i < DEPTH; i++) push(16'(16'h5000 + i));
    @(negedge clk);
    chk("full_ready_low", 32'(fill_ready), 32'd0);
    push(16'hDEAD);
    re_pulse(got); chk("rd_first_full", 32'(got), 32'h5000);
    chk("ready_after_pop", 32'(fill_ready), 32'd1);
    for (int i = 1; i < DEPTH; i++) re_pulse(got);
    chk("rd_last_full", 32'(got), 32'h500F);
    re_pulse(got); chk("dropped_push", 32'(got), 32'hFFFF);

    // Status during and after busy; non-status command rejected while busy.
    we_pulse(1'b1, 1'b0, 16'h00D0);
    we_pulse(1'b1, 1'b0, 16'h0070);
    re_pulse(got); chk("status_busy", 32'(got), 32'h0080);
    we_pulse(1'b1, 1'b0, 16'h0080);
    rb_low_len(n);
    chk("ready_wait", 32'(nand_rb_n), 32'd1);
    re_pulse(got); chk("status_ready", 32'(got), 32'h00E0);

    // Reset command mid-busy: flush, clear underrun, 16-cycle busy.
    we_pulse(1'b1, 1'b0, 16'h0000);
    push(16'h7001); push(16'h7002); push(16'h7003);
    we_pulse(1'b1, 1'b0, 16'h0010);
    repeat (8) @(negedge clk);
    we_pulse(1'b1, 1'b0, 16'h00FF);
    chk("ff_clears_underrun", 32'(underrun), 32'd0);
    rb_low_len(n);
    chk("busy_len_16", 32'(n), 32'd16);
    re_pulse(got); chk("flushed", 32'(got), 32'hFFFF);

    // Reset while RE# is held low.
    chk_en = 1'b0;
    push(16'hABCD);
    @(negedge clk);
    nand_re_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_oe", 32'(nand_dq_oe), 32'd1);
    chk("pre_rst_dq", 32'(nand_dq_out), 32'hABCD);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_re_oe", 32'(nand_dq_oe), 32'd0);
    chk("rst_re_dq", 32'(nand_dq_out), 32'hFFFF);
    chk("rst_re_underrun", 32'(underrun), 32'd0);
    nand_re_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
    $fatal(1, "timeout");
  end

endmodule
